// File: rtl/if_stage.sv
// Instruction-fetch response stage: pairs pre-IF packets with inst SRAM data_ok, buffers under ID stall,
// drops responses owed to cancelled fetches. Optional IF_PERF_CNT_EN adds fetch/discard counters.
module if_stage #(
    parameter logic [31:0] PC_RESET  = 32'h1bff_fffc,
    parameter int          PRE_BUS_W = 81,
    parameter int          ID_BUS_W  = 113
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 preIF_to_IF_valid,
    input  logic [PRE_BUS_W-1:0] preIF_to_IF_BUS,
    output logic                 IF_allowin,
    input  logic                 inst_sram_data_ok,
    input  logic [31:0]          inst_sram_rdata,
    input  logic                 ID_allowin,
    output logic                 IF_to_ID_valid,
    output logic [ID_BUS_W-1:0]  IF_to_ID_BUS,
    output logic [31:0]          if_pc,
    input  logic                 wb_flush,
    input  logic                 br_taken_cancel
`ifdef IF_PERF_CNT_EN
    ,
    output logic [31:0]          if_perf_fetched,
    output logic [31:0]          if_perf_discarded
`endif
);

    localparam logic [31:0] INST_NOP = 32'h0340_0000;

    logic                 if_valid_q, if_valid_d;
    logic                 inst_pending_q, inst_pending_d;
    logic                 buf_valid_q, buf_valid_d;
    logic [31:0]          inst_buf_q, inst_buf_d;
    logic [1:0]           discard_cnt_q, discard_cnt_d;
    logic [PRE_BUS_W-1:0] pkt_q, pkt_d;
    logic [31:0]          if_pc_q, if_pc_d;

    logic cancel, drop_rsp, data_use, ready_go, accept, leave;
    logic [31:0] inst;

    always_comb begin
        cancel   = wb_flush | br_taken_cancel;
        drop_rsp = inst_sram_data_ok & (discard_cnt_q != 2'd0);
        data_use = inst_sram_data_ok & (discard_cnt_q == 2'd0) & inst_pending_q;
        ready_go = buf_valid_q | data_use;
        IF_allowin     = ~if_valid_q | (ready_go & ID_allowin) | cancel;
        IF_to_ID_valid = if_valid_q & ready_go & ~cancel;
        accept   = preIF_to_IF_valid & IF_allowin;
        leave    = IF_to_ID_valid & ID_allowin;

        // Exception packets carry a NOP; the SRAM response is still consumed.
        if (pkt_q[PRE_BUS_W-33])
            inst = INST_NOP;
        else
            inst = buf_valid_q ? inst_buf_q : inst_sram_rdata;

        IF_to_ID_BUS = '0;
        if (if_valid_q)
            IF_to_ID_BUS = {pkt_q[PRE_BUS_W-1 -: 32], inst, pkt_q[PRE_BUS_W-33:0]};
        if_pc = if_pc_q;
    end

    always_comb begin
        if_valid_d     = if_valid_q;
        inst_pending_d = inst_pending_q;
        buf_valid_d    = buf_valid_q;
        inst_buf_d     = inst_buf_q;
        pkt_d          = pkt_q;
        if_pc_d        = if_pc_q;
        discard_cnt_d  = discard_cnt_q;

        if (drop_rsp)
            discard_cnt_d = discard_cnt_q - 2'd1;
        // A pending fetch that did not complete this cycle leaves a response in flight.
        if (cancel && inst_pending_q && !data_use && discard_cnt_d != 2'd3)
            discard_cnt_d = discard_cnt_d + 2'd1;

        if (data_use) begin
            inst_buf_d     = inst_sram_rdata;
            inst_pending_d = 1'b0;
            buf_valid_d    = ~leave;
        end

        if (cancel || leave) begin
            if_valid_d     = 1'b0;
            buf_valid_d    = 1'b0;
            inst_pending_d = 1'b0;
        end

        if (accept) begin
            if_valid_d     = 1'b1;
            inst_pending_d = 1'b1;
            buf_valid_d    = 1'b0;
            pkt_d          = preIF_to_IF_BUS;
            if_pc_d        = preIF_to_IF_BUS[PRE_BUS_W-1 -: 32];
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            if_valid_q     <= 1'b0;
            inst_pending_q <= 1'b0;
            buf_valid_q    <= 1'b0;
            inst_buf_q     <= '0;
            discard_cnt_q  <= '0;
            pkt_q          <= '0;
            if_pc_q        <= PC_RESET;
        end else begin
            if_valid_q     <= if_valid_d;
            inst_pending_q <= inst_pending_d;
            buf_valid_q    <= buf_valid_d;
            inst_buf_q     <= inst_buf_d;
            discard_cnt_q  <= discard_cnt_d;
            pkt_q          <= pkt_d;
            if_pc_q        <= if_pc_d;
        end
    end

`ifdef IF_PERF_CNT_EN
    logic [31:0] perf_fetched_q, perf_fetched_d;
    logic [31:0] perf_discarded_q, perf_discarded_d;

    always_comb begin
        perf_fetched_d   = perf_fetched_q + {31'd0, leave};
        perf_discarded_d = perf_discarded_q + {31'd0, drop_rsp};
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            perf_fetched_q   <= '0;
            perf_discarded_q <= '0;
        end else begin
            perf_fetched_q   <= perf_fetched_d;
            perf_discarded_q <= perf_discarded_d;
        end
    end

    assign if_perf_fetched   = perf_fetched_q;
    assign if_perf_discarded = perf_discarded_q;
`endif

`ifndef SYNTHESIS
    a_no_orphan_rsp: assert property (@(posedge clk) disable iff (reset)
        !(inst_sram_data_ok && !inst_pending_q && discard_cnt_q == 2'd0));
`endif

endmodule

// File: tb/tb_if_stage.sv
// Randomized + directed bench for if_stage with a queue-based fetch/response reference model and scoreboard.
module tb_if_stage;

    localparam logic [31:0] PC_RESET = 32'h1bff_fffc;
    localparam logic [31:0] NOP      = 32'h0340_0000;

    logic         clk = 1'b0;
    logic         reset;
    logic         preIF_to_IF_valid;
    logic [80:0]  preIF_to_IF_BUS;
    logic         IF_allowin;
    logic         inst_sram_data_ok;
    logic [31:0]  inst_sram_rdata;
    logic         ID_allowin;
    logic         IF_to_ID_valid;
    logic [112:0] IF_to_ID_BUS;
    logic [31:0]  if_pc;
    logic         wb_flush;
    logic         br_taken_cancel;

    always #5 clk = ~clk;

    if_stage dut (
        .clk(clk), .reset(reset),
        .preIF_to_IF_valid(preIF_to_IF_valid), .preIF_to_IF_BUS(preIF_to_IF_BUS),
        .IF_allowin(IF_allowin),
        .inst_sram_data_ok(inst_sram_data_ok), .inst_sram_rdata(inst_sram_rdata),
        .ID_allowin(ID_allowin), .IF_to_ID_valid(IF_to_ID_valid), .IF_to_ID_BUS(IF_to_ID_BUS),
        .if_pc(if_pc), .wb_flush(wb_flush), .br_taken_cancel(br_taken_cancel)
    );

    int checks   = 0;
    int failures = 0;

    // Reference model: in-flight responses in order (1 = belongs to resident packet, 0 = owed to a cancelled fetch)
    logic [112:0] scb[$];
    bit           inflight[$];
    bit           m_valid, m_have;
    logic [31:0]  m_inst, m_pc;
    logic [80:0]  m_pkt;
    bit           exp_allowin, exp_vld, chk_en;
    logic [31:0]  exp_pc;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    function automatic logic [80:0] mk(input logic [31:0] pc, input bit ex, input logic [14:0] code,
                                       input logic [31:0] va, input bit rf);
        return {pc, ex, code, va, rf};
    endfunction

    task automatic cyc(input bit pv, input logic [80:0] pb, input bit dok, input logic [31:0] rd,
                       input bit ida, input bit wbf, input bit brc);
        bit cancel, usable, ready;
        preIF_to_IF_valid = pv;  preIF_to_IF_BUS = pb;
        inst_sram_data_ok = dok; inst_sram_rdata = rd;
        ID_allowin = ida; wb_flush = wbf; br_taken_cancel = brc;

        cancel = wbf | brc;
        usable = dok && inflight.size() > 0 && inflight[0];
        ready  = m_valid && (m_have || usable);
        exp_allowin = !m_valid || (ready && ida) || cancel;
        exp_vld     = m_valid && ready && !cancel;
        exp_pc      = m_pc;
        chk_en      = 1'b1;
        if (exp_vld && ida)
            scb.push_back({m_pkt[80:49], m_pkt[48] ? NOP : (m_have ? m_inst : rd), m_pkt[48:0]});

        if (dok && inflight.size() > 0) void'(inflight.pop_front());
        if (usable) begin m_have = 1; m_inst = rd; end
        if (cancel) begin
            foreach (inflight[i]) inflight[i] = 0;
            m_valid = 0;
        end
        if (exp_vld && ida) m_valid = 0;
        if (pv && exp_allowin) begin
            m_valid = 1; m_have = 0; m_pkt = pb; m_pc = pb[80:49];
            inflight.push_back(1);
        end
        @(posedge clk); #1;
    endtask

    task automatic do_reset();
        chk_en = 1'b0;
        reset = 1'b1;
        preIF_to_IF_valid = 0; preIF_to_IF_BUS = '0; inst_sram_data_ok = 0; inst_sram_rdata = '0;
        ID_allowin = 1; wb_flush = 0; br_taken_cancel = 0;
        @(posedge clk); #1;
        @(posedge clk); #1;
        reset = 1'b0;
        m_valid = 0; m_have = 0; m_inst = '0; m_pkt = '0; m_pc = PC_RESET;
        inflight.delete(); scb.delete();
        chk("rst_allowin", IF_allowin, 1'b1);
        chk("rst_vld", IF_to_ID_valid, 1'b0);
        chk("rst_bus", IF_to_ID_BUS, 113'd0);
        chk("rst_pc", if_pc, PC_RESET);
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            chk("allowin", IF_allowin, exp_allowin);
            chk("id_valid", IF_to_ID_valid, exp_vld);
            chk("if_pc", if_pc, exp_pc);
            if (IF_to_ID_valid && ID_allowin) begin
                if (scb.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_handshake actual_bus=%0h expected=none", IF_to_ID_BUS);
                end else begin
                    chk("id_bus", IF_to_ID_BUS, scb.pop_front());
                end
            end
        end
    end

    initial begin
        logic [80:0] z;
        z = '0;
        chk_en = 0;
        @(posedge clk); #1;
        do_reset();

        // zero-cycle pass-through
        cyc(1, mk(32'h1c00_0000, 0, 15'd0, 32'd0, 0), 0, 0, 1, 0, 0);
        cyc(0, z, 1, 32'h0280_0421, 1, 0, 0);
        // ID stall around data_ok, served from buffer
        cyc(1, mk(32'h1c00_0004, 0, 15'd0, 32'd0, 0), 0, 0, 0, 0, 0);
        cyc(0, z, 0, 0, 0, 0, 0);
        cyc(0, z, 1, 32'h1234_5678, 0, 0, 0);
        cyc(0, z, 0, 32'hffff_ffff, 0, 0, 0);
        cyc(0, z, 0, 32'h0bad_0bad, 0, 0, 0);
        cyc(0, z, 0, 0, 1, 0, 0);
        // branch cancel before data_ok: first response dropped
        cyc(1, mk(32'h1c00_0010, 0, 15'd0, 32'd0, 0), 0, 0, 1, 0, 0);
        cyc(0, z, 0, 0, 1, 0, 1);
        cyc(1, mk(32'h1c00_0100, 0, 15'd0, 32'd0, 0), 0, 0, 1, 0, 0);
        cyc(0, z, 1, 32'hdead_beef, 1, 0, 0);
        cyc(0, z, 1, 32'h0000_0001, 1, 0, 0);
        // flush coincident with data_ok: no discard owed
        cyc(1, mk(32'h1c00_0200, 0, 15'd0, 32'd0, 0), 0, 0, 1, 0, 0);
        cyc(0, z, 1, 32'haaaa_aaaa, 1, 1, 0);
        cyc(1, mk(32'h1c00_0204, 0, 15'd0, 32'd0, 1), 0, 0, 1, 0, 0);
        cyc(0, z, 1, 32'h5555_5555, 1, 0, 0);
        // exception packet delivers NOP
        cyc(1, mk(32'h1c00_0002, 1, 15'h0408, 32'h1c00_0002, 0), 0, 0, 1, 0, 0);
        cyc(0, z, 1, 32'h1111_1111, 1, 0, 0);
        // build two owed discards, then reset mid-flight
        cyc(1, mk(32'h1c00_0300, 0, 15'd0, 32'd0, 0), 0, 0, 1, 0, 0);
        cyc(1, mk(32'h1c00_0304, 0, 15'd0, 32'd0, 0), 0, 0, 1, 0, 1);
        cyc(0, z, 0, 0, 1, 1, 0);
        do_reset();
        cyc(0, z, 0, 0, 1, 0, 0);

        for (int n = 0; n < 3000; n++) begin
            bit pv, dok, ida, can, wbf, brc;
            logic [80:0] pb;
            pv  = (inflight.size() < 4) && ($urandom % 2 == 0);
            pb  = mk({$urandom_range(32'h0000_ffff, 0), 2'b00} + 32'h1c00_0000, ($urandom % 8) == 0,
                     15'($urandom), $urandom, ($urandom % 16) == 0);
            dok = (inflight.size() > 0) && ($urandom % 3 != 0);
            ida = ($urandom % 4) != 0;
            can = (inflight.size() < 3) && ($urandom % 10 == 0);
            wbf = can && ($urandom % 2 == 0);
            brc = can && !wbf;
            cyc(pv, pb, dok, $urandom, ida, wbf, brc);
        end

        for (int n = 0; n < 20; n++)
            cyc(0, z, inflight.size() > 0, $urandom, 1, 0, 0);
        chk("scb_drained", scb.size(), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
